// File: rtl/piezo_pkg.sv
// piezo_pkg: note half-period constants and decoder types,
// shared by the piezo buzzer driver and the tone decoder.
package piezo_pkg;

  localparam int NOTE_N = 9;

  typedef logic [3:0] note_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    ACQ,
    LOCKED
  } dec_state_t;

  localparam logic [15:0] NOTE_DO  = 16'd11659;
  localparam logic [15:0] NOTE_RE  = 16'd10388;
  localparam logic [15:0] NOTE_MI  = 16'd9253;
  localparam logic [15:0] NOTE_PA  = 16'd8736;
  localparam logic [15:0] NOTE_SOL = 16'd7782;
  localparam logic [15:0] NOTE_RA  = 16'd6929;
  localparam logic [15:0] NOTE_SI  = 16'd6175;
  localparam logic [15:0] NOTE_HDO = 16'd5827;
  localparam logic [15:0] NOTE_HRE = 16'd5192;

  // Driver constant plus its fixed 2-cycle reload overhead
  function automatic logic [15:0] note_half(
    input note_idx_t k
  );
    logic [15:0] c;
    case (k)
      4'd0:    c = NOTE_DO;
      4'd1:    c = NOTE_RE;
      4'd2:    c = NOTE_MI;
      4'd3:    c = NOTE_PA;
      4'd4:    c = NOTE_SOL;
      4'd5:    c = NOTE_RA;
      4'd6:    c = NOTE_SI;
      4'd7:    c = NOTE_HDO;
      default: c = NOTE_HRE;
    endcase
    return c + 16'd2;
  endfunction

endpackage

// File: rtl/piezo_edge_sync.sv
// piezo_edge_sync: 2-FF synchronizer with a registered
// any-polarity edge pulse; flops reset to 1.
module piezo_edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic edge_o
);

  logic s1_q;
  logic s2_q;
  logic s3_q;
  logic edge_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      s3_q   <= 1'b1;
      edge_q <= 1'b0;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      edge_q <= s2_q ^ s3_q;
    end
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/piezo_tone_decoder.sv
// piezo_tone_decoder: half-period meter and one-hot note decoder.
// Define PIEZO_DEC_PERIOD_OUT_EN to expose PERIOD_OUT.
module piezo_tone_decoder
  import piezo_pkg::*;
#(
  parameter logic [15:0] TOL       = 16'd64,
  parameter int          MATCH_CNT = 2,
  parameter logic [15:0] TIMEOUT   = 16'd16383
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        TONE_IN,
  output logic [8:0]  KEY_OUT,
`ifdef PIEZO_DEC_PERIOD_OUT_EN
  output logic [15:0] PERIOD_OUT,
`endif
  output logic        NOTE_VALID
);

  localparam logic [2:0] LOCK_N = 3'(MATCH_CNT);

  logic              edge_w;
  logic [15:0]       cnt_q;
  dec_state_t        state_q;
  note_idx_t         cand_q;
  logic [2:0]        match_q;
  logic [8:0]        key_q;
  logic              valid_q;
  logic [NOTE_N-1:0] hit;
  note_idx_t         hit_idx;
  logic              hit_any;
  logic              same;
  logic [2:0]        nxt_match;
  logic signed [16:0] diff [NOTE_N];
  logic signed [16:0] mag  [NOTE_N];

  piezo_edge_sync u_sync (
    .clk_i  (CLK),
    .rst_i  (RESET),
    .d_i    (TONE_IN),
    .edge_o (edge_w)
  );

  always_comb begin
    hit     = '0;
    hit_idx = '0;
    for (int k = 0; k < NOTE_N; k++) begin
      diff[k] = $signed({1'b0, cnt_q})
              - $signed({1'b0, note_half(note_idx_t'(k))});
      mag[k]  = diff[k][16] ? -diff[k] : diff[k];
      hit[k]  = mag[k] <= $signed({1'b0, TOL});
      if (hit[k]) hit_idx = note_idx_t'(k);
    end
  end

  assign hit_any   = |hit;
  assign same      = (match_q != 3'd0) && (hit_idx == cand_q);
  assign nxt_match = same ? match_q + 3'd1 : 3'd1;

`ifdef PIEZO_DEC_PERIOD_OUT_EN
  logic [15:0] per_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      per_q <= '0;
    end else if (cnt_q >= TIMEOUT) begin
      per_q <= '0;
    end else if (edge_w && state_q != IDLE) begin
      per_q <= cnt_q;
    end
  end

  assign PERIOD_OUT = per_q;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
      match_q <= '0;
      key_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (edge_w) begin
        cnt_q <= 16'd1;
      end else if (cnt_q < TIMEOUT) begin
        cnt_q <= cnt_q + 16'd1;
      end
      // Timeout wins over a coincident edge, which restarts timing
      if (cnt_q >= TIMEOUT || state_q == IDLE) begin
        state_q <= edge_w ? ACQ : IDLE;
        cand_q  <= '0;
        match_q <= '0;
        key_q   <= '0;
        valid_q <= 1'b0;
      end else if (edge_w) begin
        unique case (1'b1)
          !hit_any: begin
            state_q <= ACQ;
            cand_q  <= '0;
            match_q <= '0;
            key_q   <= '0;
            valid_q <= 1'b0;
          end
          hit_any && state_q == LOCKED
            && hit_idx == cand_q: begin
            state_q <= LOCKED;
          end
          hit_any && state_q == LOCKED
            && hit_idx != cand_q: begin
            state_q <= ACQ;
            cand_q  <= hit_idx;
            match_q <= 3'd1;
            key_q   <= '0;
            valid_q <= 1'b0;
          end
          hit_any && state_q != LOCKED: begin
            cand_q  <= hit_idx;
            match_q <= nxt_match;
            if (nxt_match == LOCK_N) begin
              state_q <= LOCKED;
              key_q   <= 9'b1 << hit_idx;
              valid_q <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign KEY_OUT    = key_q;
  assign NOTE_VALID = valid_q;

endmodule
